// File: rtl/waveform_to_pipe.sv
// waveform_to_pipe: samples a 32-bit value on each sample_tick rising edge and
// streams it to an okBTPipeOut endpoint as 16-bit words, low half first.
module waveform_to_pipe #(
  parameter int unsigned DEPTH_LOG2  = 10,
  parameter int unsigned BLOCK_WORDS = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  repop,
  input  logic                  sample_tick,
  input  logic [31:0]           sample_data,
  input  logic                  ep_read,
  output logic [15:0]           ep_datain,
  output logic                  ep_ready,
  output logic [DEPTH_LOG2+1:0] fill_words,
  output logic                  overflow,
  output logic                  underflow,
  output logic [15:0]           drop_count
);

  localparam int unsigned PW    = DEPTH_LOG2;
  localparam int unsigned EW    = DEPTH_LOG2 + 1;
  localparam int unsigned FW    = DEPTH_LOG2 + 2;
  localparam int unsigned DEPTH = 32'd1 << DEPTH_LOG2;

  logic [31:0]   mem [DEPTH];

  logic          s1_q, s2_q, s3_q;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [EW-1:0] entries_q, entries_d;
  logic          half_q, half_d;
  logic [FW-1:0] fill_q, fill_d;
  logic          ready_q, ready_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;
  logic [15:0]   drop_q, drop_d;
  logic [15:0]   datain_q;

  logic          cap_c, empty_c, full_c, wr_en_c, pop_c, pop_hi_c;

  // Qualify capture and pop events; a flush discards both.
  always_comb begin
    cap_c    = s2_q & ~s3_q;
    empty_c  = (entries_q == '0);
    full_c   = (entries_q == EW'(DEPTH));
    wr_en_c  = cap_c & ~full_c & ~repop & ~reset;
    pop_c    = ep_read & ~empty_c & ~repop;
    pop_hi_c = pop_c & half_q;
  end

  // Next-state for pointers, occupancy, flags and the fill counter.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    entries_d   = entries_q;
    half_d      = half_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    drop_d      = drop_q;
    ready_d     = (fill_q >= FW'(BLOCK_WORDS));

    if (repop) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      entries_d = '0;
      half_d    = 1'b0;
      ready_d   = 1'b0;
    end else begin
      if (wr_en_c) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_hi_c) rd_ptr_d = rd_ptr_q + PW'(1);
      if (pop_c) half_d = ~half_q;
      entries_d = entries_q + EW'(wr_en_c) - EW'(pop_hi_c);
      if (cap_c && full_c) begin
        overflow_d = 1'b1;
        if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
      end
      if (ep_read && empty_c) underflow_d = 1'b1;
    end

    fill_d = {entries_d, 1'b0} - FW'(half_d);
  end

  // State registers, including the tick synchronizer and its history flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      s3_q        <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      entries_q   <= '0;
      half_q      <= 1'b0;
      fill_q      <= '0;
      ready_q     <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      drop_q      <= '0;
    end else begin
      s1_q        <= sample_tick;
      s2_q        <= s1_q;
      s3_q        <= s2_q;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      entries_q   <= entries_d;
      half_q      <= half_d;
      fill_q      <= fill_d;
      ready_q     <= ready_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      drop_q      <= drop_d;
    end
  end

  // Sample storage: one write port, no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en_c) mem[wr_ptr_q] <= sample_data;
  end

  // Registered read port; an empty read returns zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      datain_q <= '0;
    end else if (ep_read && !repop) begin
      if (empty_c)     datain_q <= '0;
      else if (half_q) datain_q <= mem[rd_ptr_q][31:16];
      else             datain_q <= mem[rd_ptr_q][15:0];
    end
  end

  assign ep_datain  = datain_q;
  assign ep_ready   = ready_q;
  assign fill_words = fill_q;
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_waveform_to_pipe.sv
// Bench for waveform_to_pipe using a 16-entry FIFO and 16-word blocks.
module tb_waveform_to_pipe;

  localparam int unsigned DL = 4;
  localparam int unsigned BW = 16;
  localparam int unsigned NENT = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          repop = 1'b0;
  logic          sample_tick = 1'b0;
  logic [31:0]   sample_data = '0;
  logic          ep_read = 1'b0;
  logic [15:0]   ep_datain;
  logic          ep_ready;
  logic [DL+1:0] fill_words;
  logic          overflow;
  logic          underflow;
  logic [15:0]   drop_count;

  waveform_to_pipe #(.DEPTH_LOG2(DL), .BLOCK_WORDS(BW)) dut (
    .clk(clk), .reset(reset), .repop(repop), .sample_tick(sample_tick),
    .sample_data(sample_data), .ep_read(ep_read), .ep_datain(ep_datain),
    .ep_ready(ep_ready), .fill_words(fill_words), .overflow(overflow),
    .underflow(underflow), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: queue of pending 16-bit words in host order.
  logic [15:0] wq[$];
  bit          m_ovf = 0;
  bit          m_unf = 0;
  int          m_drops = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic m_push(input logic [31:0] d);
    if ((wq.size() + 1) / 2 == NENT) begin
      m_ovf = 1;
      if (m_drops < 65535) m_drops++;
    end else begin
      wq.push_back(d[15:0]);
      wq.push_back(d[31:16]);
    end
  endtask

  task automatic m_pop(output logic [15:0] w);
    if (wq.size() == 0) begin
      w = 16'h0000;
      m_unf = 1;
    end else begin
      w = wq.pop_front();
    end
  endtask

  task automatic check_state(input string tag);
    @(negedge clk);
    chk({tag, ".fill"}, 32'(fill_words), 32'(wq.size()));
    chk({tag, ".ready"}, 32'(ep_ready), 32'(wq.size() >= BW));
    chk({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
    chk({tag, ".unf"}, 32'(underflow), 32'(m_unf));
    chk({tag, ".drops"}, 32'(drop_count), 32'(m_drops));
  endtask

  // One full tick period: high for 4 cycles, low for 3.
  task automatic do_tick(input logic [31:0] d);
    @(negedge clk);
    sample_data = d;
    sample_tick = 1'b1;
    repeat (4) @(negedge clk);
    m_push(d);
    sample_tick = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic read_burst(input int n, input string tag);
    logic [15:0] w;
    @(negedge clk);
    ep_read = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      m_pop(w);
      chk({tag, ".word"}, 32'(ep_datain), 32'(w));
    end
    ep_read = 1'b0;
  endtask

  task automatic do_repop();
    @(negedge clk);
    repop = 1'b1;
    @(negedge clk);
    repop = 1'b0;
    wq.delete();
  endtask

  initial begin
    logic [15:0] w;
    int prev;
    int cur;

    // Reset values.
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst.datain", 32'(ep_datain), 32'h0);
    chk("rst.ready", 32'(ep_ready), 32'h0);
    chk("rst.fill", 32'(fill_words), 32'h0);
    chk("rst.ovf", 32'(overflow), 32'h0);
    chk("rst.unf", 32'(underflow), 32'h0);
    chk("rst.drops", 32'(drop_count), 32'h0);

    // Basic ordering: 8 samples fill exactly one block.
    for (int n = 0; n < 8; n++) begin
      do_tick(32'h0001_0000 + 32'(n));
      if (n == 6) check_state("order.pre");
    end
    check_state("order.full");
    chk("order.ready_hi", 32'(ep_ready), 32'h1);
    read_burst(16, "order");
    check_state("order.end");

    // Underflow: read while empty, then a normal capture.
    read_burst(1, "unf");
    check_state("unf.flags");
    chk("unf.sticky", 32'(underflow), 32'h1);
    do_tick(32'hCAFE_BEEF);
    read_burst(2, "unf.after");
    check_state("unf.end");

    // Overflow: 20 samples into 16 entries.
    for (int n = 0; n < 20; n++) do_tick(32'hA000_0000 + 32'(n * 3));
    check_state("ovf.full");
    chk("ovf.fill32", 32'(fill_words), 32'd32);
    chk("ovf.drops4", 32'(drop_count), 32'd4);
    read_burst(32, "ovf");
    check_state("ovf.end");

    // Capture concurrent with continuous pops, at several phases.
    for (int ph = 0; ph < 4; ph++) begin
      for (int k = 0; k < 4; k++) do_tick(32'h5000_0000 + 32'(ph * 16 + k));
      @(negedge clk);
      prev = int'(fill_words);
      fork
        begin
          repeat (ph) @(negedge clk);
          sample_data = 32'h7700_0000 + 32'(ph);
          sample_tick = 1'b1;
          repeat (4) @(negedge clk);
          sample_tick = 1'b0;
        end
        begin
          ep_read = 1'b1;
          for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            m_pop(w);
            chk("conc.word", 32'(ep_datain), 32'(w));
            cur = int'(fill_words);
            chk("conc.delta", 32'((cur == prev + 1) || (cur + 1 == prev)), 32'h1);
            prev = cur;
          end
          ep_read = 1'b0;
        end
      join
      m_push(32'h7700_0000 + 32'(ph));
      repeat (3) @(negedge clk);
      check_state("conc.after");
      read_burst(2, "conc.tail");
    end

    // Flush after reading only a low half.
    do_tick(32'h1111_2222);
    do_tick(32'h3333_4444);
    read_burst(1, "flush.pre");
    do_repop();
    check_state("flush");
    chk("flush.ovf_kept", 32'(overflow), 32'h1);
    do_tick(32'h5555_6666);
    read_burst(2, "flush.after");

    // Randomized mix of captures, read bursts and flushes.
    for (int op = 0; op < 60; op++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 5) do_tick($urandom);
      else if (r < 9) read_burst(int'($urandom_range(1, 6)), "rnd");
      else do_repop();
      check_state("rnd");
    end

    // Reset in the middle of a read burst.
    for (int n = 0; n < 10; n++) do_tick(32'hB000_0000 + 32'(n));
    @(negedge clk);
    ep_read = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      m_pop(w);
      chk("mid.word", 32'(ep_datain), 32'(w));
    end
    reset = 1'b1;
    @(negedge clk);
    chk("mid.datain", 32'(ep_datain), 32'h0);
    chk("mid.ready", 32'(ep_ready), 32'h0);
    chk("mid.fill", 32'(fill_words), 32'h0);
    chk("mid.ovf", 32'(overflow), 32'h0);
    chk("mid.unf", 32'(underflow), 32'h0);
    chk("mid.drops", 32'(drop_count), 32'h0);
    reset = 1'b0;
    ep_read = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
